// File: rtl/down_counter.sv
// Loadable, cascadable down-counter/timer: counts a loaded value to zero, emits a
// registered one-cycle borrow pulse, then stops (one-shot) or reloads (auto-reload).
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             count,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] a_count,
    output logic             b_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_s;
    logic             borrow_r;
    logic             borrow_s;

    // Registers for state, count value, reload value and borrow pulse
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_r  <= ST_IDLE;
            count_r  <= {WIDTH{1'b0}};
            reload_r <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            reload_r <= reload_s;
            borrow_r <= borrow_s;
        end
    end

    // Next-state logic; the terminal event at zero replaces the wrap to all-ones
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        reload_s = reload_r;
        borrow_s = 1'b0;
        if (load) begin
            count_s  = din;
            reload_s = din;
            state_s  = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (count) begin
                        if (count_r != {WIDTH{1'b0}}) begin
                            count_s = count_r - WIDTH'(1);
                        end else begin
                            borrow_s = 1'b1;
                            if (mode) begin
                                count_s = reload_r;
                            end else begin
                                state_s = ST_DONE;
                            end
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                ST_IDLE: state_s = ST_IDLE;
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    assign a_count = count_r;
    assign b_out   = borrow_r;
    assign busy    = (state_r == ST_RUN);
    assign done    = (state_r == ST_DONE);

endmodule
